// File: rtl/distortion_core.sv
// Per-sample distortion stage for the I2S receiver outputs: LRCLK edge detect, capture,
// Q4.4 gain, then bypass / hard clip / soft clip shaping, 4-cycle latency from detection.
module distortion_core #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              BCLK,
    input  logic              reset,
    input  logic              LRCLK,
    input  logic [DATA_W-1:0] left_in,
    input  logic [DATA_W-1:0] right_in,
    input  logic [7:0]        gain,
    input  logic [DATA_W-2:0] threshold,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] left_out,
    output logic [DATA_W-1:0] right_out,
    output logic              sample_valid,
    output logic              sample_is_right
);

    localparam int unsigned ProdW   = DATA_W + 9;
    localparam int unsigned ScaledW = ProdW - 4;
    localparam logic [ScaledW-1:0] MaxMag = ScaledW'((1 << (DATA_W - 1)) - 1);

    typedef enum logic [1:0] {
        ModeBypass  = 2'b00,
        ModeHard    = 2'b01,
        ModeSoft    = 2'b10,
        ModeHardAlt = 2'b11
    } mode_e;

    // Edge detection
    logic lrclk_q;
    logic primed_q;
    logic lrclk_edge;

    // Pipeline valid bits
    logic det_v_q, s1_v_q, s2_v_q, s3_v_q;

    // Pipeline datapath
    logic                      det_right_q;
    logic                      s1_right_q;
    logic signed [DATA_W-1:0]  s1_sample_q;
    logic [7:0]                s1_gain_q;
    logic [DATA_W-2:0]         s1_thr_q;
    mode_e                     s1_mode_q;
    logic                      s2_right_q;
    logic [DATA_W-1:0]         s2_sample_q;
    logic signed [ScaledW-1:0] s2_scaled_q;
    logic [DATA_W-2:0]         s2_thr_q;
    mode_e                     s2_mode_q;
    logic                      s3_right_q;
    logic [DATA_W-1:0]         s3_result_q;

    // Stage 2 / stage 3 combinational results
    logic signed [ProdW-1:0]   prod;
    logic signed [ScaledW-1:0] scaled;
    logic [ScaledW-1:0]        scaled_u;
    logic                      neg;
    logic [ScaledW-1:0]        mag;
    logic [ScaledW-1:0]        thr_ext;
    logic [ScaledW-1:0]        excess;
    logic [ScaledW-1:0]        hard_mag;
    logic [ScaledW-1:0]        soft_mag;
    logic [ScaledW-1:0]        shaped;
    logic [ScaledW-1:0]        sat_mag;
    logic [DATA_W-1:0]         sat_lo;
    logic [DATA_W-1:0]         result;

    // The first cycle after reset only primes lrclk_q, so a high LRCLK never reads as an edge.
    assign lrclk_edge = primed_q && (lrclk_q != LRCLK);

    always_comb begin
        prod   = ProdW'(s1_sample_q) * ProdW'($signed({1'b0, s1_gain_q}));
        scaled = prod[ProdW-1:4];
    end

    always_comb begin
        scaled_u = s2_scaled_q;
        neg      = s2_scaled_q[ScaledW-1];
        mag      = neg ? -scaled_u : scaled_u;
        thr_ext  = ScaledW'(s2_thr_q);
        excess   = mag - thr_ext;
        hard_mag = (mag < thr_ext) ? mag : thr_ext;
        soft_mag = (mag <= thr_ext) ? mag : thr_ext + (excess >> 2);
        shaped   = hard_mag;
        result   = s2_sample_q;
        case (s2_mode_q)
            ModeSoft: shaped = soft_mag;
            default:  shaped = hard_mag;
        endcase
        sat_mag = (shaped > MaxMag) ? MaxMag : shaped;
        sat_lo  = sat_mag[DATA_W-1:0];
        if (s2_mode_q != ModeBypass) begin
            result = neg ? -sat_lo : sat_lo;
        end
    end

    // Control path: valid bits, edge priming and the visible outputs.
    always_ff @(posedge BCLK) begin
        if (reset) begin
            lrclk_q         <= 1'b0;
            primed_q        <= 1'b0;
            det_v_q         <= 1'b0;
            s1_v_q          <= 1'b0;
            s2_v_q          <= 1'b0;
            s3_v_q          <= 1'b0;
            sample_valid    <= 1'b0;
            sample_is_right <= 1'b0;
            left_out        <= '0;
            right_out       <= '0;
        end else begin
            lrclk_q      <= LRCLK;
            primed_q     <= 1'b1;
            det_v_q      <= lrclk_edge;
            s1_v_q       <= det_v_q;
            s2_v_q       <= s1_v_q;
            s3_v_q       <= s2_v_q;
            sample_valid <= s3_v_q;
            if (s3_v_q) begin
                sample_is_right <= s3_right_q;
                if (s3_right_q) begin
                    right_out <= s3_result_q;
                end else begin
                    left_out <= s3_result_q;
                end
            end
        end
    end

    // Datapath registers advance every cycle; the valid bits decide what is meaningful.
    // Capture waits one cycle so the receiver's word published on the detect edge is seen.
    always_ff @(posedge BCLK) begin
        det_right_q <= ~LRCLK;
        s1_right_q  <= det_right_q;
        s1_sample_q <= det_right_q ? right_in : left_in;
        s1_gain_q   <= gain;
        s1_thr_q    <= threshold;
        s1_mode_q   <= mode_e'(mode);
        s2_right_q  <= s1_right_q;
        s2_sample_q <= s1_sample_q;
        s2_scaled_q <= scaled;
        s2_thr_q    <= s1_thr_q;
        s2_mode_q   <= s1_mode_q;
        s3_right_q  <= s2_right_q;
        s3_result_q <= result;
    end

endmodule

// File: tb/tb_distortion_core.sv
// Self-checking bench for distortion_core: directed vector table, randomized samples against
// an integer reference model, and hand-written reset / snapshot / back-to-back sequences.
module tb_distortion_core;

    logic        BCLK = 1'b0;
    logic        reset = 1'b1;
    logic        LRCLK = 1'b0;
    logic [15:0] left_in = '0;
    logic [15:0] right_in = '0;
    logic [7:0]  gain = 8'h10;
    logic [14:0] threshold = '0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] left_out;
    logic [15:0] right_out;
    logic        sample_valid;
    logic        sample_is_right;

    int  n_tests = 0;
    int  n_fail = 0;
    time det_t = 0;

    distortion_core #(.DATA_W(16)) dut (
        .BCLK            (BCLK),
        .reset           (reset),
        .LRCLK           (LRCLK),
        .left_in         (left_in),
        .right_in        (right_in),
        .gain            (gain),
        .threshold       (threshold),
        .mode            (mode),
        .left_out        (left_out),
        .right_out       (right_out),
        .sample_valid    (sample_valid),
        .sample_is_right (sample_is_right)
    );

    always #5 BCLK = ~BCLK;

    typedef struct {
        logic [15:0] din;
        logic [7:0]  g;
        logic [14:0] t;
        logic [1:0]  m;
        logic [15:0] exp;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Reference: gain as a real multiply with floor division by 16, then clip rules on integers.
    function automatic logic [15:0] model(input logic [15:0] din, input logic [7:0] g,
                                          input logic [14:0] t, input logic [1:0] m);
        int x, p, s, a, ti, r;
        x  = int'($signed(din));
        ti = int'(t);
        p  = x * int'(g);
        s  = (p >= 0) ? p / 16 : -((-p + 15) / 16);
        if (m == 2'b00) return din;
        a = (s < 0) ? -s : s;
        if (m == 2'b10) r = (a <= ti) ? a : ti + (a - ti) / 4;
        else            r = (a < ti) ? a : ti;
        if (r > 32767) r = 32767;
        if (s < 0) r = -r;
        return r[15:0];
    endfunction

    // Toggle LRCLK, then publish the word on the detect edge as the receiver would.
    task automatic start_edge(input logic [15:0] val, output logic right);
        LRCLK = ~LRCLK;
        right = ~LRCLK;
        if (right) right_in = ~val;
        else       left_in  = ~val;
        @(posedge BCLK);
        det_t = $time;
        #1;
        if (right) right_in = val;
        else       left_in  = val;
    endtask

    task automatic wait_check(input string name, input logic right, input logic [15:0] exp);
        bit got;
        int k;
        int lat;
        got = 1'b0;
        k   = 0;
        while (!got && k < 12) begin
            @(negedge BCLK);
            if (sample_valid) got = 1'b1;
            k++;
        end
        check({name, "_valid"}, 32'(got), 32'd1);
        if (got) begin
            lat = int'(($time - det_t - 5) / 10);
            check({name, "_latency"}, lat, 32'd4);
            check({name, "_is_right"}, 32'(sample_is_right), 32'(right));
            check({name, "_data"}, right ? right_out : left_out, exp);
            @(negedge BCLK);
            check({name, "_pulse_width"}, 32'(sample_valid), 32'd0);
        end
    endtask

    initial begin
        logic        r;
        logic [15:0] d;
        logic [15:0] e;
        int          pulses;

        // Reset state
        repeat (3) @(posedge BCLK);
        #1 reset = 1'b0;
        @(negedge BCLK);
        check("rst_left_out", left_out, 0);
        check("rst_right_out", right_out, 0);
        check("rst_valid", sample_valid, 0);
        check("rst_is_right", sample_is_right, 0);
        repeat (2) @(negedge BCLK);

        // Bypass with capture-delay check
        mode = 2'b00;
        start_edge(16'h1234, r);
        wait_check("bypass_left", 1'b0, 16'h1234);
        start_edge(16'hEDCC, r);
        wait_check("bypass_right", 1'b1, 16'hEDCC);
        check("bypass_left_hold", left_out, 16'h1234);

        // Directed vector table
        vecs.push_back('{16'd3000, 8'h20, 15'd10000, 2'b01, 16'd6000});
        vecs.push_back('{-16'sd3000, 8'h20, 15'd10000, 2'b01, -16'sd6000});
        vecs.push_back('{16'd8000, 8'h20, 15'd10000, 2'b01, 16'd10000});
        vecs.push_back('{-16'sd8000, 8'h20, 15'd10000, 2'b01, -16'sd10000});
        vecs.push_back('{16'd8000, 8'h40, 15'd20000, 2'b10, 16'd23000});
        vecs.push_back('{-16'sd8000, 8'h40, 15'd20000, 2'b10, -16'sd23000});
        vecs.push_back('{16'h8000, 8'hFF, 15'd32767, 2'b10, -16'sd32767});
        vecs.push_back('{16'h8000, 8'hFF, 15'd32767, 2'b01, -16'sd32767});
        vecs.push_back('{16'h8000, 8'hFF, 15'd32767, 2'b00, 16'h8000});
        vecs.push_back('{16'd5000, 8'h10, 15'd0, 2'b01, 16'd0});
        vecs.push_back('{16'd5000, 8'h10, 15'd0, 2'b10, 16'd1250});
        vecs.push_back('{-16'sd5000, 8'h10, 15'd0, 2'b10, -16'sd1250});
        vecs.push_back('{16'd3000, 8'h20, 15'd1000, 2'b11, 16'd1000});
        vecs.push_back('{16'd1000, 8'h10, 15'd20000, 2'b10, 16'd1000});
        vecs.push_back('{16'hFFFF, 8'h18, 15'd100, 2'b01, 16'hFFFE});
        vecs.push_back('{16'h7FFF, 8'h11, 15'd30000, 2'b10, 16'd31203});
        vecs.push_back('{16'h7FFF, 8'h11, 15'd32767, 2'b01, 16'd32767});
        foreach (vecs[i]) begin
            gain      = vecs[i].g;
            threshold = vecs[i].t;
            mode      = vecs[i].m;
            start_edge(vecs[i].din, r);
            wait_check($sformatf("vec%0d", i), r, vecs[i].exp);
        end

        // Randomized samples against the reference model
        for (int i = 0; i < 150; i++) begin
            d         = 16'($urandom);
            gain      = 8'($urandom);
            threshold = (i % 4 == 0) ? 15'($urandom_range(0, 64)) : 15'($urandom);
            mode      = 2'($urandom_range(0, 3));
            e         = model(d, gain, threshold, mode);
            start_edge(d, r);
            wait_check($sformatf("rand%0d", i), r, e);
        end

        // Control snapshot: gain changes right after capture of the in-flight sample
        mode      = 2'b01;
        threshold = 15'd32767;
        gain      = 8'h10;
        start_edge(16'd1000, r);
        @(posedge BCLK);
        #1 gain = 8'h80;
        wait_check("snap_inflight", r, 16'd1000);
        start_edge(16'd1000, r);
        wait_check("snap_next", r, 16'd8000);

        // Back-to-back edges: left then right on consecutive cycles
        mode = 2'b00;
        if (LRCLK) begin
            start_edge(16'h0001, r);
            wait_check("bb_align", 1'b1, 16'h0001);
        end
        left_in  = 16'h0BAD;
        right_in = 16'h0BAD;
        LRCLK    = 1'b1;
        @(posedge BCLK);
        det_t = $time;
        #1;
        left_in = 16'hA5A5;
        LRCLK   = 1'b0;
        @(posedge BCLK);
        #1 right_in = 16'h5A5A;
        pulses = 0;
        while (!sample_valid && pulses < 12) begin
            @(negedge BCLK);
            pulses++;
        end
        check("bb_first_valid", sample_valid, 1);
        check("bb_first_latency", int'(($time - det_t - 5) / 10), 4);
        check("bb_first_is_right", sample_is_right, 0);
        check("bb_first_data", left_out, 16'hA5A5);
        @(negedge BCLK);
        check("bb_second_valid", sample_valid, 1);
        check("bb_second_is_right", sample_is_right, 1);
        check("bb_second_data", right_out, 16'h5A5A);
        check("bb_left_hold", left_out, 16'hA5A5);
        @(negedge BCLK);
        check("bb_end_valid", sample_valid, 0);

        // Reset two cycles after a detected edge flushes the sample
        start_edge(16'h4321, r);
        @(posedge BCLK);
        #1 reset = 1'b1;
        pulses = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge BCLK);
            if (sample_valid) pulses++;
            if (k == 2) reset = 1'b0;
        end
        check("midrst_pulses", pulses, 0);
        check("midrst_left_out", left_out, 0);
        check("midrst_right_out", right_out, 0);
        check("midrst_is_right", sample_is_right, 0);

        // LRCLK held high through reset release: nothing until the first real falling edge
        reset = 1'b1;
        LRCLK = 1'b1;
        repeat (3) @(posedge BCLK);
        #1 reset = 1'b0;
        pulses = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge BCLK);
            if (sample_valid) pulses++;
        end
        check("lrhigh_pulses", pulses, 0);
        mode      = 2'b01;
        gain      = 8'h20;
        threshold = 15'd10000;
        start_edge(-16'sd3000, r);
        wait_check("lrhigh_first_fall", 1'b1, -16'sd6000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running, want finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/distortion_core.md
# distortion_core

Per-sample distortion stage placed directly downstream of the I2S receiver. It watches `LRCLK` to learn when the receiver has published a new `left` or `right` word. It then captures that word and applies Q4.4 gain followed by clipping: bypass, hard clip, or soft clip. The results are presented as registered `left_out`/`right_out` words with a one-cycle `sample_valid` strobe. Everything runs in the `BCLK` domain, so no clock crossing is needed between receiver and effect.

## Interface
- `DATA_W`, 16: sample width. The block is only specified and verified at 16.
- `BCLK`  in  1  codec bit clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `LRCLK`  in  1  codec left/right clock. It is the same signal the receiver sees.
- `left_in`  in  16  signed left sample from the receiver.
- `right_in`  in  16  signed right sample from the receiver.
- `gain`  in  8  unsigned Q4.4 gain. 0x10 = 1.0; 0xFF = 15.9375.
- `threshold`  in  15  unsigned clip level, 0..32767.
- `mode`  in  2  00 bypass, 01 hard clip, 10 soft clip, 11 treated as hard clip.
- `left_out`  out  16  signed processed left sample.
- `right_out`  out  16  signed processed right sample.
- `sample_valid`  out  1  one-cycle pulse when `left_out` or `right_out` updates.
- `sample_is_right`  out  1  channel of the most recent update: 0 = left, 1 = right.

## Operation
- **Edge detection.** `lrclk_d` registers `LRCLK` every cycle.
  - An edge is `lrclk_d != LRCLK` at a `BCLK` rising edge: rising edge = left, falling edge = right.
  - The first cycle after reset deasserts only primes `lrclk_d`. No edge is reported on that cycle.
- **Capture, one cycle after detection.** The receiver updates its output on the same edge on which the LRCLK edge is detected, so capture waits one cycle.
  - Stage 1 latches the channel flag and the matching input: `left_in` for left, `right_in` for right.
  - Stage 1 also snapshots `gain`, `threshold` and `mode`. Control changes therefore never affect a sample already in flight.
- **Stage 2, gain.**
  - `p` = `sample × {1'b0, gain}`, a 25-bit signed product.
  - `s` = `p >>> 4`, arithmetic shift, a 21-bit signed result.
- **Stage 3, shape.** Let `a = |s|`, `t = threshold`, and sign = sign of `s`.
  - **Bypass:** result = the original captured sample. No gain and no saturation are applied.
  - **Hard:** result = sign·min(`a`, `t`).
  - **Soft:** if `a <= t`, result = `s`. Otherwise result = sign·(`t` + ((`a` − `t`) >> 2)).
  - **Final saturation (hard and soft only):** clamp to [−32767, +32767]. −32768 is never produced in these modes.
  - **Threshold 0:** hard mode outputs 0. Soft mode outputs sign·(`a` >> 2), saturated.
- **Stage 4, output.** The result is written to `left_out` or `right_out` according to the channel flag. The other output holds its value. `sample_valid` pulses and `sample_is_right` is set to the flag.
- **Pipelining.** The pipeline is fully pipelined and accepts a new edge every cycle. A back-to-back left/right edge pair therefore produces two consecutive valid pulses.

## Timing
- Edge detected at `BCLK` edge N. Capture at N+1, gain at N+2, shape at N+3. Outputs and `sample_valid` change at N+4, so latency is 4 cycles from detection.
- `sample_valid` is high for exactly one cycle per detected `LRCLK` edge.
- Reset values: `left_out` = 0, `right_out` = 0, `sample_valid` = 0, `sample_is_right` = 0. All pipeline valid bits are 0 and the priming flag is cleared.
- Reset asserted mid-pipeline flushes all in-flight samples. No `sample_valid` pulse is emitted for them, including in the cycle reset deasserts.
- An `LRCLK` level other than 0 at reset release produces no spurious edge.

## Test plan
- **Bypass, and capture-delay check.**
  - Stimulus: mode 00, `left_in` = 0x1234, `right_in` = 0xEDCC. `left_in` changes in the same cycle as the `LRCLK` rising edge.
  - Required: `left_out` = 0x1234, `sample_valid` pulses exactly 4 cycles after detection, `sample_is_right` = 0.
  - Then the falling edge gives `right_out` = 0xEDCC with `sample_is_right` = 1.
- **Hard clip.**
  - Stimulus: mode 01, gain 0x20 (2.0), threshold 10000; inputs 3000, −3000, 8000, −8000.
  - Required: outputs 6000, −6000, 10000, −10000.
- **Soft clip and saturation.**
  - Stimulus: mode 10, gain 0x40 (4.0), threshold 20000; input 8000 (s = 32000).
  - Required: output 23000.
  - Stimulus: input −32768 with gain 0xFF and threshold 32767.
  - Required: output −32767.
- **Control snapshot.**
  - Stimulus: change `gain` from 0x10 to 0x80 one cycle after capture.
  - Required: the in-flight sample uses gain 1.0. The next sample uses gain 8.0.
- **Reset behaviour.**
  - Stimulus: hold `LRCLK` = 1 through reset release.
  - Required: no `sample_valid` until the first real falling edge.
  - Stimulus: assert reset 2 cycles after a detected edge.
  - Required: no pulse for that sample, and all outputs = 0.
- **Back-to-back edges.**
  - Stimulus: `LRCLK` toggles on two consecutive cycles.
  - Required: two consecutive `sample_valid` pulses, left then right, each carrying the correct data.
